ps2_interface: RTL and testbench

- PS/2 keyboard receiver clocked directly by the keyboard's PS2Clk line.
- Deserialises 11-bit PS/2 frames, checks the framing and odd parity, and decodes the byte stream into a held make code plus a key-down flag.
- Sits between the keyboard pins and the application logic that consumes key state.

---
 rtl/ps2_interface.sv | 89 ++++++++
 tb/tb_ps2_interface.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_interface.sv
// PS/2 keyboard receiver running directly off the keyboard's PS2Clk line.
// Deserialises 11-bit frames, checks framing and odd parity, and tracks the held make code.
module ps2_interface #(
  parameter logic [7:0] BREAK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE   = 8'hE0
) (
  input  logic       PS2Clk,
  input  logic       rstn,
  input  logic       PS2Data,
  output logic [7:0] scancode,
  output logic       keyPressed
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0] r_state;
  logic [2:0] r_count;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_break;
  logic [7:0] r_scancode;
  logic       r_key;

  logic       w_parity_ok;
  logic       w_frame_ok;

  // Odd parity over the data byte plus the parity bit; the stop bit must be 1.
  assign w_parity_ok = ^{r_shift, r_parity};
  assign w_frame_ok  = PS2Data & w_parity_ok;

  always_ff @(negedge PS2Clk) begin
    if (rstn) begin
      r_state    <= S_IDLE;
      r_count    <= 3'd0;
      r_shift    <= 8'h00;
      r_parity   <= 1'b0;
      r_break    <= 1'b0;
      r_scancode <= 8'h00;
      r_key      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!PS2Data) begin
            r_state <= S_DATA;
            r_count <= 3'd0;
          end
        end
        S_DATA: begin
          r_shift[r_count] <= PS2Data;
          r_count          <= r_count + 3'd1;
          if (r_count == 3'd7) begin
            r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          r_parity <= PS2Data;
          r_state  <= S_STOP;
        end
        S_STOP: begin
          // Decode happens on the stop edge itself so the outputs move with no extra latency.
          r_state <= S_IDLE;
          if (w_frame_ok && (r_shift != EXT_CODE)) begin
            if (r_shift == BREAK_CODE) begin
              r_break <= 1'b1;
            end else if (r_break) begin
              r_break <= 1'b0;
              if (r_shift == r_scancode) begin
                r_key <= 1'b0;
              end
            end else begin
              r_scancode <= r_shift;
              r_key      <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign scancode   = r_scancode;
  assign keyPressed = r_key;

endmodule

// File: tb/tb_ps2_interface.sv
// Bench for ps2_interface: directed scenarios plus a randomized byte stream checked
// against a key-state model built from the decode rules.
module tb_ps2_interface;

  logic       PS2Clk;
  logic       rstn;
  logic       PS2Data;
  logic [7:0] scancode;
  logic       keyPressed;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] exp_code;
  logic       exp_key;
  logic       m_brk;
  logic [8:0] exp_q[$];

  ps2_interface dut (
    .PS2Clk    (PS2Clk),
    .rstn      (rstn),
    .PS2Data   (PS2Data),
    .scancode  (scancode),
    .keyPressed(keyPressed)
  );

  // clock / reset
  initial PS2Clk = 1'b1;
  always #10 PS2Clk = ~PS2Clk;

  // ---------------- model ----------------
  task automatic m_reset();
    exp_code = 8'h00;
    exp_key  = 1'b0;
    m_brk    = 1'b0;
  endtask

  task automatic m_frame(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = $countones(d) + int'(p);
    if (s && (ones % 2 == 1)) begin
      if (d == 8'hE0) begin
      end else if (d == 8'hF0) begin
        m_brk = 1'b1;
      end else if (m_brk) begin
        m_brk = 1'b0;
        if (d == exp_code) exp_key = 1'b0;
      end else begin
        exp_code = d;
        exp_key  = 1'b1;
      end
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b);
    @(posedge PS2Clk);
    #2 PS2Data = b;
    @(negedge PS2Clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_head(d, p);
    drive_bit(s);
    m_frame(d, p, s);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, odd_par(d), 1'b1);
  endtask

  task automatic reset_edges(input int n);
    @(posedge PS2Clk);
    #2 rstn = 1'b1;
    PS2Data = 1'b1;
    repeat (n) @(negedge PS2Clk);
    #1;
    m_reset();
    @(posedge PS2Clk);
    #2 rstn = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_edges(3);
    n_tests++;
    if (scancode !== 8'h00 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: scancode=%h keyPressed=%b expected 00/0", scancode, keyPressed);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    n_tests++;
    if (scancode !== 8'h00 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: scancode=%h keyPressed=%b expected 00/0", scancode, keyPressed);
    end
  endtask

  task automatic test_make();
    send_head(8'h17, 1'b1);
    n_tests++;
    if (scancode !== 8'h00 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL make_before_stop: scancode=%h keyPressed=%b expected 00/0", scancode, keyPressed);
    end
    drive_bit(1'b1);
    m_frame(8'h17, 1'b1, 1'b1);
    n_tests++;
    if (scancode !== 8'h17 || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL make: scancode=%h keyPressed=%b expected 17/1", scancode, keyPressed);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      send_good(8'h17);
      n_tests++;
      if (scancode !== 8'h17 || keyPressed !== 1'b1) begin
        n_fail++;
        $display("FAIL typematic[%0d]: scancode=%h keyPressed=%b expected 17/1", k, scancode, keyPressed);
      end
    end
  endtask

  task automatic test_release();
    send_frame(8'hF0, 1'b1, 1'b1);
    n_tests++;
    if (scancode !== 8'h17 || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL release_prefix: scancode=%h keyPressed=%b expected 17/1", scancode, keyPressed);
    end
    send_good(8'h17);
    n_tests++;
    if (scancode !== 8'h17 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL release: scancode=%h keyPressed=%b expected 17/0", scancode, keyPressed);
    end
  endtask

  task automatic test_second_key();
    send_frame(8'h16, 1'b0, 1'b1);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL second_make: scancode=%h keyPressed=%b expected 16/1", scancode, keyPressed);
    end
    send_good(8'hF0);
    send_good(8'h16);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL second_release: scancode=%h keyPressed=%b expected 16/0", scancode, keyPressed);
    end
  endtask

  task automatic test_errors();
    send_frame(8'h17, 1'b0, 1'b1);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_parity: scancode=%h keyPressed=%b expected 16/0", scancode, keyPressed);
    end
    send_frame(8'h17, 1'b1, 1'b0);
    drive_bit(1'b1);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_stop: scancode=%h keyPressed=%b expected 16/0", scancode, keyPressed);
    end
    send_good(8'h16);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL remake: scancode=%h keyPressed=%b expected 16/1", scancode, keyPressed);
    end
    send_good(8'hF0);
    send_good(8'h1C);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL foreign_release: scancode=%h keyPressed=%b expected 16/1", scancode, keyPressed);
    end
    send_good(8'hE0);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_prefix: scancode=%h keyPressed=%b expected 16/1", scancode, keyPressed);
    end
    // an accepted F0 with bad stop must not arm the break flag
    send_frame(8'hF0, 1'b1, 1'b0);
    drive_bit(1'b1);
    send_good(8'h16);
    n_tests++;
    if (scancode !== 8'h16 || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_break_frame: scancode=%h keyPressed=%b expected 16/1", scancode, keyPressed);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_good(8'hF0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset_edges(1);
    n_tests++;
    if (scancode !== 8'h00 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: scancode=%h keyPressed=%b expected 00/0", scancode, keyPressed);
    end
    drive_bit(1'b1);
    send_good(8'h1C);
    n_tests++;
    if (scancode !== 8'h1C || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_make: scancode=%h keyPressed=%b expected 1C/1", scancode, keyPressed);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [8:0] got;
    logic [8:0] want;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: d = 8'h17;
        1: d = 8'h16;
        2: d = 8'h1C;
        3, 4: d = 8'hF0;
        5: d = 8'hE0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      p = odd_par(d);
      s = 1'b1;
      case ($urandom_range(0, 7))
        0: p = ~p;
        1: s = 1'b0;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      send_frame(d, p, s);
      if (!s) drive_bit(1'b1);
      exp_q.push_back({exp_key, exp_code});
      got  = {keyPressed, scancode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random[%0d] byte=%h p=%b s=%b: got key/code=%b/%h expected %b/%h",
                 n, d, p, s, got[8], got[7:0], want[8], want[7:0]);
      end
    end
  endtask

  initial begin
    rstn    = 1'b1;
    PS2Data = 1'b1;
    m_reset();
    test_reset();
    test_make();
    test_back_to_back();
    test_release();
    test_second_key();
    test_errors();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
